// File: rtl/memory_access_unit_pkg.sv
// Shared types and constants for the data-memory access stage.
//   access_size_t : transfer size encoding as presented on the size input
//   mem_state_t   : request/acknowledge FSM states
//   BE_*          : byte-enable base patterns, shifted by the lane select
//   normalize_size: folds the reserved encoding 2'b11 onto WORD
package memory_access_unit_pkg;

  typedef enum logic [1:0] {
    SIZE_BYTE = 2'b00,
    SIZE_HALF = 2'b01,
    SIZE_WORD = 2'b10
  } access_size_t;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'b00,
    ST_ACCESS   = 2'b01,
    ST_COMPLETE = 2'b10
  } mem_state_t;

  localparam logic [3:0] BE_BYTE = 4'b0001;
  localparam logic [3:0] BE_HALF = 4'b0011;
  localparam logic [3:0] BE_WORD = 4'b1111;

  function automatic access_size_t normalize_size(input logic [1:0] raw);
    access_size_t s;
    case (raw)
      2'b00:   s = SIZE_BYTE;
      2'b01:   s = SIZE_HALF;
      default: s = SIZE_WORD;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/memory_access_unit_load_align.sv
// Combinational load lane extractor and extender.
//   readData   : raw word returned by the bus
//   laneSel    : address[1:0] of the access
//   size       : BYTE / HALF / WORD
//   signExtend : 1 = sign-extend, 0 = zero-extend (BYTE/HALF only)
//   result     : aligned, extended 32-bit load value
module memory_access_unit_load_align
  import memory_access_unit_pkg::*;
(
  input  logic [31:0]  readData,
  input  logic [1:0]   laneSel,
  input  access_size_t size,
  input  logic         signExtend,
  output logic [31:0]  result
);

  logic [7:0]  byte_lane;
  logic [15:0] half_lane;

  always_comb begin
    byte_lane = readData[7:0];
    case (laneSel)
      2'd1:    byte_lane = readData[15:8];
      2'd2:    byte_lane = readData[23:16];
      2'd3:    byte_lane = readData[31:24];
      default: byte_lane = readData[7:0];
    endcase

    // Halfwords are only ever aligned here, so address bit 1 picks the half.
    half_lane = laneSel[1] ? readData[31:16] : readData[15:0];

    case (size)
      SIZE_BYTE: result = {{24{signExtend & byte_lane[7]}}, byte_lane};
      SIZE_HALF: result = {{16{signExtend & half_lane[15]}}, half_lane};
      default:   result = readData;
    endcase
  end

endmodule

// File: rtl/memory_access_unit.sv
// Data-memory access stage: issues one single-beat bus transaction per
// request, generating byte enables and lane-replicated store data, and
// aligning/extending load data on the way back. A request/acknowledge FSM
// with a wait-cycle timeout reports completion or fault via done.
//   clk, reset(active-low, async)
//   start/load/size/signExtend/address/storeData : request from address unit
//   busAddress/busRead/busWrite/busByteEn/busWriteData : bus request side
//   busReadData/busAck/busError                  : bus response side
//   busy/done/loadData/misalignFault/busFault     : status to control unit
module memory_access_unit
  import memory_access_unit_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter int unsigned TIMEOUT_WIDTH  = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        load,
  input  logic [1:0]  size,
  input  logic        signExtend,
  input  logic [31:0] address,
  input  logic [31:0] storeData,
  output logic [31:0] busAddress,
  output logic        busRead,
  output logic        busWrite,
  output logic [3:0]  busByteEn,
  output logic [31:0] busWriteData,
  input  logic [31:0] busReadData,
  input  logic        busAck,
  input  logic        busError,
  output logic        busy,
  output logic        done,
  output logic [31:0] loadData,
  output logic        misalignFault,
  output logic        busFault
);

  // Counter value seen in the last permitted wait cycle.
  localparam logic [TIMEOUT_WIDTH-1:0] TIMEOUT_LAST = TIMEOUT_WIDTH'(TIMEOUT_CYCLES - 1);

  mem_state_t               state_q, state_d;
  logic                     load_q, load_d;
  access_size_t             size_q, size_d;
  logic                     sign_ext_q, sign_ext_d;
  logic [1:0]               lane_q, lane_d;
  logic [31:0]              bus_address_q, bus_address_d;
  logic [3:0]               byte_en_q, byte_en_d;
  logic [31:0]              wdata_q, wdata_d;
  logic [31:0]              load_data_q, load_data_d;
  logic                     misalign_q, misalign_d;
  logic                     bus_fault_q, bus_fault_d;
  logic [TIMEOUT_WIDTH-1:0] wait_cnt_q, wait_cnt_d;

  access_size_t req_size;
  logic         misaligned;
  logic [3:0]   be_calc;
  logic [31:0]  wdata_calc;
  logic [31:0]  aligned_data;

  assign req_size = normalize_size(size);

  always_comb begin
    misaligned = 1'b0;
    be_calc    = BE_WORD;
    case (req_size)
      SIZE_BYTE: be_calc = BE_BYTE << address[1:0];
      SIZE_HALF: begin
        be_calc    = BE_HALF << address[1:0];
        misaligned = address[0];
      end
      default: begin
        be_calc    = BE_WORD;
        misaligned = |address[1:0];
      end
    endcase
  end

  // Each output lane carries the low byte (BYTE), the matching byte of the
  // low half (HALF), or its own byte (WORD).
  for (genvar gi = 0; gi < 4; gi++) begin : g_wlane
    assign wdata_calc[8*gi +: 8] =
        (req_size == SIZE_BYTE) ? storeData[7:0] :
        (req_size == SIZE_HALF) ? storeData[8*(gi%2) +: 8] :
                                  storeData[8*gi +: 8];
  end

  memory_access_unit_load_align u_load_align (
    .readData   (busReadData),
    .laneSel    (lane_q),
    .size       (size_q),
    .signExtend (sign_ext_q),
    .result     (aligned_data)
  );

  always_comb begin
    state_d       = state_q;
    load_d        = load_q;
    size_d        = size_q;
    sign_ext_d    = sign_ext_q;
    lane_d        = lane_q;
    bus_address_d = bus_address_q;
    byte_en_d     = byte_en_q;
    wdata_d       = wdata_q;
    load_data_d   = load_data_q;
    misalign_d    = misalign_q;
    bus_fault_d   = bus_fault_q;
    wait_cnt_d    = wait_cnt_q;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          load_d        = load;
          size_d        = req_size;
          sign_ext_d    = signExtend;
          lane_d        = address[1:0];
          bus_address_d = {address[31:2], 2'b00};
          byte_en_d     = be_calc;
          wdata_d       = wdata_calc;
          misalign_d    = misaligned;
          bus_fault_d   = 1'b0;
          wait_cnt_d    = '0;
          // A misaligned request never reaches the bus.
          state_d       = misaligned ? ST_COMPLETE : ST_ACCESS;
        end
      end

      ST_ACCESS: begin
        wait_cnt_d = wait_cnt_q + TIMEOUT_WIDTH'(1);
        if (busError) begin
          // Error takes priority over a simultaneous ack; data is discarded.
          bus_fault_d = 1'b1;
          state_d     = ST_COMPLETE;
        end else if (busAck) begin
          if (load_q) begin
            load_data_d = aligned_data;
          end
          state_d = ST_COMPLETE;
        end else if (wait_cnt_q == TIMEOUT_LAST) begin
          bus_fault_d = 1'b1;
          state_d     = ST_COMPLETE;
        end
      end

      ST_COMPLETE: begin
        misalign_d  = 1'b0;
        bus_fault_d = 1'b0;
        wait_cnt_d  = '0;
        state_d     = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= ST_IDLE;
      load_q        <= 1'b0;
      size_q        <= SIZE_BYTE;
      sign_ext_q    <= 1'b0;
      lane_q        <= 2'b00;
      bus_address_q <= '0;
      byte_en_q     <= '0;
      wdata_q       <= '0;
      load_data_q   <= '0;
      misalign_q    <= 1'b0;
      bus_fault_q   <= 1'b0;
      wait_cnt_q    <= '0;
    end else begin
      state_q       <= state_d;
      load_q        <= load_d;
      size_q        <= size_d;
      sign_ext_q    <= sign_ext_d;
      lane_q        <= lane_d;
      bus_address_q <= bus_address_d;
      byte_en_q     <= byte_en_d;
      wdata_q       <= wdata_d;
      load_data_q   <= load_data_d;
      misalign_q    <= misalign_d;
      bus_fault_q   <= bus_fault_d;
      wait_cnt_q    <= wait_cnt_d;
    end
  end

  // Strobes come straight from the state register so reset drops them at once.
  assign busRead       = (state_q == ST_ACCESS) &  load_q;
  assign busWrite      = (state_q == ST_ACCESS) & ~load_q;
  assign busy          = (state_q != ST_IDLE);
  assign done          = (state_q == ST_COMPLETE);
  assign busAddress    = bus_address_q;
  assign busByteEn     = byte_en_q;
  assign busWriteData  = wdata_q;
  assign loadData      = load_data_q;
  assign misalignFault = misalign_q;
  assign busFault      = bus_fault_q;

endmodule

// File: doc/memory_access_unit.md
Name: memory_access_unit

Overview:
- Data-memory access stage directly downstream of the address unit. Consumes the registered effective address and issues one single-beat bus transaction per request.
- Stores: generates byte enables and lane-replicated write data.
- Loads: extracts byte/halfword from the returned word and zero- or sign-extends it.
- Owns a request/acknowledge FSM with timeout. Reports completion or fault to the CPU control unit.

Parameters:
- TIMEOUT_CYCLES, 255: max cycles to wait for busAck/busError before a bus fault; legal range 1..65535.
- TIMEOUT_WIDTH, 16: width of the internal wait counter; must hold TIMEOUT_CYCLES.

Ports:
- clk  input  1  system clock; all state updates on rising edge
- reset  input  1  asynchronous, active-low reset (asserted at 0)
- start  input  1  request strobe; sampled only in IDLE
- load  input  1  1 = load, 0 = store
- size  input  2  BYTE=00, HALF=01, WORD=10; 11 is treated as WORD
- signExtend  input  1  loads only: 1 = sign-extend, 0 = zero-extend
- address  input  32  effective address from the address unit; low 2 bits select the lane
- storeData  input  32  store operand; only the low byte/half is used for BYTE/HALF
- busAddress  output  32  word-aligned address ({address[31:2],2'b00})
- busRead  output  1  read strobe, held until response
- busWrite  output  1  write strobe, held until response
- busByteEn  output  4  active byte lanes
- busWriteData  output  32  replicated store data
- busReadData  input  32  read data, valid with busAck
- busAck  input  1  transfer complete
- busError  input  1  slave error, terminates the transfer
- busy  output  1  high whenever state != IDLE
- done  output  1  one-cycle completion pulse (success or fault)
- loadData  output  32  aligned and extended load result; holds until the next load completes
- misalignFault  output  1  valid with done: HALF with address[0]=1, or WORD with address[1:0]!=0
- busFault  output  1  valid with done: busError or timeout

Behaviour:
- Reset (async, reset=0):
  - state=IDLE.
  - All outputs 0: busAddress, busByteEn, busWriteData, loadData, strobes, busy, done, faults.
  - Wait counter cleared.
  - Reset mid-transaction drops the strobes immediately; no done is produced.
- States: IDLE, ACCESS, COMPLETE.
- IDLE, start=1 (cycle 0):
  - Latch load, size, signExtend and address[1:0].
  - Drive busAddress, busByteEn and busWriteData as registered outputs.
  - If misaligned: go to COMPLETE with misalignFault=1; no strobe is ever asserted.
  - Otherwise: go to ACCESS.
- ACCESS:
  - busRead=load, busWrite=!load, held with all bus outputs stable.
  - Wait counter increments each cycle.
  - busAck: capture aligned loadData (loads only) and go to COMPLETE.
  - busError: go to COMPLETE with busFault=1; loadData is unchanged.
  - busAck and busError in the same cycle: error wins.
  - Counter reaching TIMEOUT_CYCLES with no response: go to COMPLETE with busFault=1.
  - Strobes deassert on the cycle after the response.
- COMPLETE: done=1 for exactly 1 cycle, faults valid, then IDLE. start during COMPLETE is ignored.
- Latency, aligned access:
  - start at cycle 0, strobe from cycle 1.
  - busAck at cycle 1 gives done at cycle 2 (minimum 2-cycle latency).
  - Misaligned access: done at cycle 1.
- start while busy: ignored, with no queueing.
- Byte enables:
  - BYTE: 4'b0001 << a[1:0].
  - HALF: 4'b0011 << a[1:0].
  - WORD: 4'b1111.
- Write data:
  - BYTE: {4{sd[7:0]}}.
  - HALF: {2{sd[15:0]}}.
  - WORD: sd.
- Load extract:
  - BYTE: rd[8*a+7 : 8*a].
  - HALF: rd[16*a[1]+15 : 16*a[1]].
  - Extended to 32 bits per signExtend.
- Faults clear in the cycle after done.

Decomposition:
- Package memoryGroup:
  - accessSize enum {BYTE, HALF, WORD}.
  - memState enum {IDLE, ACCESS, COMPLETE}.
  - Localparam byte-enable base patterns.
- Sub-module load_align: combinational lane extractor and extender.
  - Inputs: readData, laneSel[1:0], size, signExtend.
  - Output: 32-bit result.
  - Unit-testable in isolation.

Test Plan:
- Store word: addr 0x1000, sd 0xDEADBEEF, busAck on the first strobe cycle → busAddress 0x1000, byteEn 1111, wdata 0xDEADBEEF, done at cycle 2, no faults.
- Load byte, signed: addr 0x2003, rd 0x80FF_0000, busAck after 3 wait cycles → byteEn 1000, loadData 0xFFFF_FF80, done at cycle 5.
- Load half, zero-extend: addr 0x2002, rd 0x8001_1234 → byteEn 1100, loadData 0x0000_8001.
- Misaligned word: addr 0x3001 → no busRead/busWrite ever, done and misalignFault at cycle 1.
- Timeout with TIMEOUT_CYCLES=4: no ack → strobe held 4 cycles, then done with busFault, loadData unchanged. Also cover busAck together with busError → busFault=1.
- Reset low mid-ACCESS, plus start while busy → strobes 0 asynchronously, no done, state IDLE; a second start during ACCESS produces no extra transaction.
